// File: rtl/bit_scan_if.sv
// ---------------------------------------------------------------------------
// bit_scan_if
// Bundles the two valid/ready channels of the set-bit enumerator.
//   Input channel : in_valid / in_ready / in        (word to enumerate)
//   Output channel: out_valid / out_ready / out_index / out_count /
//                   out_last / out_none             (one beat per set bit)
// Modports:
//   master : the producer/consumer side (drives in_valid, in, out_ready)
//   slave  : the bit_scan block itself
// ---------------------------------------------------------------------------
interface bit_scan_if #(
  parameter int ORDER = 3
);
  localparam int W = 2 ** ORDER;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in;
  logic             out_valid;
  logic             out_ready;
  logic [ORDER-1:0] out_index;
  logic [ORDER:0]   out_count;
  logic             out_last;
  logic             out_none;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out_index, out_count, out_last, out_none
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out_index, out_count, out_last, out_none
  );
endinterface

// File: rtl/bit_scan.sv
// ---------------------------------------------------------------------------
// bit_scan
// Sequential set-bit enumerator. Accepts a W-bit word (W = 2**ORDER) and then
// emits the index of every set bit, lowest first, one beat per cycle, along
// with a 1-based running ordinal and a last-beat flag. An all-zero word
// produces a single beat flagged out_none.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : bit_scan_if.slave (input and output valid/ready channels)
// ---------------------------------------------------------------------------
module bit_scan #(
  parameter int ORDER = 3
) (
  input  logic       clock,
  input  logic       reset,
  bit_scan_if.slave  bus
);
  localparam int W = 2 ** ORDER;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_word;
  logic [ORDER:0]   r_count;

  state_t           w_state_next;
  logic [W-1:0]     w_word_next;
  logic [ORDER:0]   w_count_next;

  logic [ORDER-1:0] w_index;
  logic [W-1:0]     w_word_cleared;
  logic             w_none;
  logic             w_last;

  // Clearing the lowest set bit also tells us whether this is the final beat:
  // if nothing remains after clearing it, there is no further set bit.
  assign w_word_cleared = r_word & (r_word - 1'b1);
  assign w_none         = (r_word == '0);
  assign w_last         = (w_word_cleared == '0);

  // Trailing-zero count: scan from the top so the lowest set bit wins.
  always_comb begin
    w_index = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (r_word[i]) begin
        w_index = ORDER'(i);
      end
    end
  end

  assign bus.out_index = w_index;
  assign bus.out_count = r_count;
  assign bus.out_last  = w_last;
  assign bus.out_none  = w_none;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_word  <= w_word_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_word_next   = r_word;
    w_count_next  = r_count;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_word_next  = bus.in;
          // An empty word reports ordinal 0 on its single beat.
          w_count_next = (bus.in != '0) ? {{ORDER{1'b0}}, 1'b1} : '0;
          w_state_next = BUSY;
        end
      end

      BUSY: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (w_last) begin
            // word/count are left as-is; they are reloaded on the next accept.
            w_state_next = IDLE;
          end else begin
            w_word_next  = w_word_cleared;
            w_count_next = r_count + 1'b1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_bit_scan.sv
module tb_bit_scan;
  localparam int ORDER = 3;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  bit_scan_if #(.ORDER(ORDER)) bif ();

  bit_scan #(.ORDER(ORDER)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input int cnt, input int last, input int none);
    $display("[TB] %s beat: index=%0d count=%0d last=%0b none=%0b valid=%0b in_ready=%0b",
             tag, bif.out_index, bif.out_count, bif.out_last, bif.out_none,
             bif.out_valid, bif.in_ready);
    check({tag, " out_valid"}, 32'(bif.out_valid), 32'd1);
    check({tag, " in_ready"},  32'(bif.in_ready),  32'd0);
    check({tag, " out_index"}, 32'(bif.out_index), 32'(idx));
    check({tag, " out_count"}, 32'(bif.out_count), 32'(cnt));
    check({tag, " out_last"},  32'(bif.out_last),  32'(last));
    check({tag, " out_none"},  32'(bif.out_none),  32'(none));
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle in_ready"},  32'(bif.in_ready),  32'd1);
    check({tag, " idle out_valid"}, 32'(bif.out_valid), 32'd0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer one word in IDLE for exactly one cycle; afterwards the first beat is visible.
  task automatic send_word(input logic [7:0] w);
    $display("[TB] send word %02h", w);
    bif.in_valid = 1'b1;
    bif.in       = w;
    step();
    bif.in_valid = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset         = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in        = '0;
    bif.out_ready = 1'b0;

    // Reset state
    #2;
    check("rst in_ready",  32'(bif.in_ready),  32'd1);
    check("rst out_valid", 32'(bif.out_valid), 32'd0);
    check("rst out_index", 32'(bif.out_index), 32'd0);
    check("rst out_count", 32'(bif.out_count), 32'd0);
    check("rst out_last",  32'(bif.out_last),  32'd1);
    check("rst out_none",  32'(bif.out_none),  32'd1);
    @(negedge clock);
    reset = 1'b0;
    step();
    bif.out_ready = 1'b1;

    // A5: beats (0,1,0),(2,2,0),(5,3,0),(7,4,1)
    send_word(8'hA5);
    check_beat("A5 b0", 0, 1, 0, 0); step();
    check_beat("A5 b1", 2, 2, 0, 0); step();
    check_beat("A5 b2", 5, 3, 0, 0); step();
    check_beat("A5 b3", 7, 4, 1, 0); step();
    check_idle("A5 end");

    // Empty word: single beat flagged none
    send_word(8'h00);
    check_beat("00 b0", 0, 0, 1, 1); step();
    check_idle("00 end");

    // Single top bit
    send_word(8'h80);
    check_beat("80 b0", 7, 1, 1, 0); step();
    check_idle("80 end");

    // FF with two stall cycles before every handshake
    send_word(8'hFF);
    for (int b = 0; b < 8; b++) begin
      bif.out_ready = 1'b0;
      check_beat($sformatf("FF b%0d", b), b, b + 1, (b == 7) ? 1 : 0, 0);
      step();
      check_beat($sformatf("FF b%0d stall1", b), b, b + 1, (b == 7) ? 1 : 0, 0);
      step();
      check_beat($sformatf("FF b%0d stall2", b), b, b + 1, (b == 7) ? 1 : 0, 0);
      bif.out_ready = 1'b1;
      step();
    end
    check_idle("FF end");

    // in_valid held high: 03 accepted, 0C offered during BUSY
    bif.in_valid = 1'b1;
    bif.in       = 8'h03;
    step();
    bif.in = 8'h0C;
    check_beat("03 b0", 0, 1, 0, 0); step();
    check_beat("03 b1", 1, 2, 1, 0); step();
    check_idle("03 end");
    step();
    bif.in_valid = 1'b0;
    check_beat("0C b0", 2, 1, 0, 0); step();
    check_beat("0C b1", 3, 2, 1, 0); step();
    check_idle("0C end");

    // Reset mid-word
    send_word(8'hF0);
    check_beat("F0 b0", 4, 1, 0, 0); step();
    check_beat("F0 b1", 5, 2, 0, 0);
    reset = 1'b1;
    #1;
    check("midrst out_valid", 32'(bif.out_valid), 32'd0);
    check("midrst in_ready",  32'(bif.in_ready),  32'd1);
    check("midrst out_count", 32'(bif.out_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();
    send_word(8'h01);
    check_beat("01 b0", 0, 1, 1, 0); step();
    check_idle("01 end");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
